switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//  Conditions raw slide-switch/push-button inputs of the Nexys3 board for synchronous logic.
//  Per bit: 2-flop synchronizer, tick-based debounce filter, then clean level plus 1-cycle rise/fall strobes.
//  Sits between the Sw/btn pins and the LED/7-seg display logic.
//  All outputs are in the clk domain.
// PARAMETERS
//  WIDTH         8        number of input bits conditioned
//  TICK_DIV      100000   clk cycles per debounce tick (1 ms at 100 MHz); must be >= 1
//  STABLE_TICKS  10       consecutive ticks an input must differ from level_out before level_out flips; >= 1
//  REPEAT_TICKS  250      auto-repeat period in ticks (used only with SWDB_REPEAT_EN)
// PORTS
//  clk         in   1      system clock, 100 MHz
//  rst         in   1      synchronous reset, active-high
//  raw_in      in   WIDTH  asynchronous switch/button pins
//  level_out   out  WIDTH  debounced level
//  rise_pulse  out  WIDTH  1-cycle strobe when level_out goes 0->1 (plus repeats, see CONFIGURATION)
//  fall_pulse  out  WIDTH  1-cycle strobe when level_out goes 1->0
//  any_change  out  1      OR-reduction of rise_pulse | fall_pulse
// BEHAVIOUR
//  - Reset: sync flops, tick counter, per-bit counters, level_out, rise_pulse, fall_pulse, any_change all 0.
//    Reset is honoured every cycle it is high. A bit held high through reset re-qualifies and produces a rise_pulse.
//  - Synchronizer: s1 <= raw_in; s2 <= s1. Latency raw->s2 is 2 cycles.
//  - Tick: tick_cnt counts 0..TICK_DIV-1 and wraps to 0.
//    tick = (tick_cnt == TICK_DIV-1), high for 1 cycle.
//    Counter width: $clog2(TICK_DIV) (min 1). TICK_DIV=1 means tick is high every cycle.
//  - Per bit i, counter cnt_i of width $clog2(STABLE_TICKS+1):
//      s2[i] == level_out[i]: cnt_i <= 0 on that cycle (any bounce back restarts qualification).
//      s2[i] != level_out[i] && tick && cnt_i == STABLE_TICKS-1: level_out[i] <= s2[i]; cnt_i <= 0; strobe asserted.
//      s2[i] != level_out[i] && tick (otherwise): cnt_i <= cnt_i + 1.
//      no tick: cnt_i holds.
//  - Strobes are registered and coincide with the level_out update cycle; width exactly 1 clk. any_change is registered in the same cycle.
//  - Qualification latency after input settles: 2 sync cycles + between (STABLE_TICKS-1)*TICK_DIV+1 and STABLE_TICKS*TICK_DIV cycles.
//  - Bits are independent. Simultaneous flips on several bits give strobes on all of them in the same cycle.
//  - rise_pulse[i] and fall_pulse[i] are never both high.
// CONFIGURATION
//  SWDB_REPEAT_EN defined:
//    - While level_out[i]==1, a per-bit repeat counter advances on each tick.
//    - Every REPEAT_TICKS ticks after the rise it re-emits rise_pulse[i] (and any_change).
//    - The counter clears when level_out[i]==0 and on reset.
//  SWDB_REPEAT_EN undefined:
//    - No repeat logic is instantiated; REPEAT_TICKS is ignored.
//    - Exactly one rise_pulse per debounced press.
// STRUCTURE
//  - Shared package/header nexys3_defs: CLK_HZ=100_000_000, NUM_SW=8, NUM_BTN=5, DEBOUNCE_MS=10.
//  - Top level owns the synchronizer and the single shared tick generator.
//  - Sub-module debounce_bit (one per bit via generate) holds cnt_i, level, strobe regs and the optional repeat counter.
//    Inputs: clk, rst, tick, din. Outputs: level, rise, fall.
// TESTING  (bench params: WIDTH=4, TICK_DIV=4, STABLE_TICKS=3, REPEAT_TICKS=2)
//  1. rst high 3 cycles with raw_in=4'hF -> all outputs 0 during reset. After release: level_out=4'hF within 2+12 cycles; rise_pulse=4'hF for exactly 1 cycle.
//  2. raw_in[0] 0->1, held -> rise_pulse[0] 1 cycle; level_out[0]=1 between 11 and 14 cycles after the edge; fall_pulse stays 0.
//  3. raw_in[1] toggles every 5 cycles for 60 cycles, then settles at 0 -> level_out[1] stays 0; no strobes on bit 1.
//  4. raw_in[2] and raw_in[3] fall in the same cycle from level 1 -> fall_pulse=4'b1100 in a single cycle; any_change=1 that cycle only.
//  5. Reset asserted midway through a bit-0 qualification (cnt=1) -> cnt and level_out cleared. Re-qualification takes the full 3 ticks.
//  6. Run with SWDB_REPEAT_EN, bit 0 held -> rise_pulse[0] at qualification, then every 8 cycles. Without the macro: a single pulse only.

Source files
------------

// File: rtl/switch_debouncer_pkg.sv
// Board-level constants and helpers for the Nexys3 switch/button
// conditioning path.
//
// Contents:
//   CLK_HZ, NUM_SW, NUM_BTN, DEBOUNCE_MS  board constants
//   clog2_min1()                          counter width helper, never returns 0
package switch_debouncer_pkg;

    localparam int CLK_HZ      = 100_000_000;
    localparam int NUM_SW      = 8;
    localparam int NUM_BTN     = 5;
    localparam int DEBOUNCE_MS = 10;

    // A counter that only ever needs to hold 0 still needs one flop.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/switch_debouncer_bit.sv
// Single-bit debounce filter driven by the shared debounce tick.
//
// Optional feature macro: SWDB_REPEAT_EN (auto-repeat of the rise strobe
// while the debounced level stays high).
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous reset, active-high
//   tick  in   1-cycle debounce tick from the shared tick generator
//   din   in   synchronized input bit
//   level out  debounced level
//   rise  out  1-cycle strobe on 0->1 (and on repeats when enabled)
//   fall  out  1-cycle strobe on 1->0
module debounce_bit
    import switch_debouncer_pkg::*;
#(
    parameter int STABLE_TICKS = 10,
    parameter int REPEAT_TICKS = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = clog2_min1(STABLE_TICKS + 1);

    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic          w_differs;
    logic          w_qualify;
    logic          w_repeat;

    assign w_differs = (din != r_level);
    assign w_qualify = w_differs && tick && (r_cnt == CW'(STABLE_TICKS - 1));

`ifdef SWDB_REPEAT_EN
    localparam int RW = clog2_min1(REPEAT_TICKS);

    logic [RW-1:0] r_rep;

    // A falling qualification wins over a repeat landing on the same tick.
    assign w_repeat = r_level && tick && !w_qualify && (r_rep == RW'(REPEAT_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst || !r_level) begin
            r_rep <= '0;
        end else if (tick) begin
            r_rep <= (r_rep == RW'(REPEAT_TICKS - 1)) ? '0 : r_rep + 1'b1;
        end
    end
`else
    logic w_unused_repeat;

    assign w_repeat        = 1'b0;
    assign w_unused_repeat = (REPEAT_TICKS > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= (w_qualify && din) || w_repeat;
            r_fall <= w_qualify && !din;
            if (!w_differs) begin
                // Any bounce back to the current level restarts qualification.
                r_cnt <= '0;
            end else if (w_qualify) begin
                r_level <= din;
                r_cnt   <= '0;
            end else if (tick) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule

// File: rtl/switch_debouncer.sv
// Conditions raw Nexys3 switch/button pins: per bit a 2-flop synchronizer,
// a tick-based debounce filter, a clean level and 1-cycle rise/fall strobes.
//
// Optional feature macro: SWDB_REPEAT_EN (auto-repeat of rise_pulse while a
// bit stays debounced high, every REPEAT_TICKS ticks).
//
// Ports:
//   clk         in   system clock (100 MHz)
//   rst         in   synchronous reset, active-high
//   raw_in      in   WIDTH asynchronous pins
//   level_out   out  WIDTH debounced levels
//   rise_pulse  out  WIDTH 1-cycle 0->1 strobes
//   fall_pulse  out  WIDTH 1-cycle 1->0 strobes
//   any_change  out  OR of all strobes
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int WIDTH        = NUM_SW,
    parameter int TICK_DIV     = CLK_HZ / 1000,
    parameter int STABLE_TICKS = DEBOUNCE_MS,
    parameter int REPEAT_TICKS = 250
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    localparam int TW = clog2_min1(TICK_DIV);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [TW-1:0]    r_tick_cnt;
    logic             w_tick;
    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= raw_in;
            r_s2 <= r_s1;
        end
    end

    // With TICK_DIV=1 the counter sits at 0 and the tick fires every cycle.
    assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_debounce_bit (
            .clk   (clk),
            .rst   (rst),
            .tick  (w_tick),
            .din   (r_s2[gi]),
            .level (w_level[gi]),
            .rise  (w_rise[gi]),
            .fall  (w_fall[gi])
        );
    end

    assign level_out  = w_level;
    assign rise_pulse = w_rise;
    assign fall_pulse = w_fall;
    // OR of registered strobes: changes in the same cycle as the strobes.
    assign any_change = |(w_rise | w_fall);

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer (WIDTH=4, TICK_DIV=4, STABLE_TICKS=3,
// REPEAT_TICKS=2). Expected behaviour follows SWDB_REPEAT_EN if defined.
module tb_switch_debouncer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] raw_in = 4'h0;
    logic [3:0] level_out;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic       any_change;

    int errors = 0;
    int checks = 0;

    switch_debouncer #(
        .WIDTH        (4),
        .TICK_DIV     (4),
        .STABLE_TICKS (3),
        .REPEAT_TICKS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .any_change (any_change)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        raw_in = 4'hF;
        rst    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({level_out, rise_pulse, fall_pulse, any_change} !== 13'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %b, want all 0", c,
                         {level_out, rise_pulse, fall_pulse, any_change});
            end
        end
        rst = 1'b0;
        n = 0;
        while (n < 20 && level_out !== 4'hF) begin
            step();
            n++;
        end
        checks++;
        if (n != 12 || level_out !== 4'hF) begin
            errors++;
            $display("FAIL reset_requalify: level_out=%h after %0d cycles, want F after 12", level_out, n);
        end
        checks++;
        if (rise_pulse !== 4'hF || any_change !== 1'b1) begin
            errors++;
            $display("FAIL reset_rise: rise=%h any=%b, want F/1", rise_pulse, any_change);
        end
        step();
        checks++;
        if (rise_pulse !== 4'h0 || any_change !== 1'b0) begin
            errors++;
            $display("FAIL reset_rise_width: rise=%h any=%b, want 0/0", rise_pulse, any_change);
        end
    endtask

    // Drives raw_in to a new value and watches 16 cycles of strobes.
    task automatic fall_window(input logic [3:0] new_raw, input logic [3:0] exp_fall,
                               input string name);
        int fall_cycles = 0;
        int any_cycles  = 0;
        int rise_cycles = 0;
        int bad_any     = 0;
        logic [3:0] seen = 4'h0;
        raw_in = new_raw;
        for (int c = 0; c < 16; c++) begin
            step();
            if (fall_pulse !== 4'h0) begin
                fall_cycles++;
                seen = fall_pulse;
                if (any_change !== 1'b1) bad_any++;
            end
            if (any_change === 1'b1) any_cycles++;
            if (rise_pulse !== 4'h0) rise_cycles++;
        end
        checks++;
        if (fall_cycles != 1 || seen !== exp_fall) begin
            errors++;
            $display("FAIL %s_fall: %0d strobe cycles value %b, want 1 cycle %b", name,
                     fall_cycles, seen, exp_fall);
        end
        checks++;
        if (any_cycles != 1 || bad_any != 0) begin
            errors++;
            $display("FAIL %s_any_change: %0d cycles (%0d misaligned), want 1 aligned", name,
                     any_cycles, bad_any);
        end
        checks++;
        if (rise_cycles != 0) begin
            errors++;
            $display("FAIL %s_no_rise: %0d rise cycles, want 0", name, rise_cycles);
        end
        checks++;
        if (level_out !== new_raw) begin
            errors++;
            $display("FAIL %s_level: got %h, want %h", name, level_out, new_raw);
        end
    endtask

    task automatic test_pair_fall_low();
        fall_window(4'hC, 4'h3, "pair_low");
    endtask

    task automatic test_simultaneous_fall();
        fall_window(4'h0, 4'hC, "simul");
    endtask

    task automatic test_rise();
        int n = 0;
        int rises = 0;
        int falls = 0;
        raw_in = 4'h1;
        while (n < 20 && level_out[0] !== 1'b1) begin
            step();
            n++;
            if (rise_pulse[0] === 1'b1) rises++;
            if (fall_pulse !== 4'h0) falls++;
        end
        checks++;
        if (n < 11 || n > 14 || level_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL rise_latency: %0d cycles level=%b, want 11..14 and 1", n, level_out[0]);
        end
        checks++;
        if (rise_pulse !== 4'h1) begin
            errors++;
            $display("FAIL rise_strobe: rise=%b at level update, want 0001", rise_pulse);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            if (rise_pulse[0] === 1'b1) rises++;
            if (fall_pulse !== 4'h0) falls++;
        end
        checks++;
        if (rises != 1 || falls != 0) begin
            errors++;
            $display("FAIL rise_count: rises=%0d falls=%0d, want 1/0", rises, falls);
        end
    endtask

    task automatic test_bounce();
        int bad = 0;
        for (int c = 0; c < 60; c++) begin
            if (c % 5 == 0) raw_in[1] = ~raw_in[1];
            step();
            if (level_out[1] !== 1'b0 || rise_pulse[1] !== 1'b0 || fall_pulse[1] !== 1'b0) bad++;
        end
        raw_in[1] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (level_out[1] !== 1'b0 || rise_pulse[1] !== 1'b0 || fall_pulse[1] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bounce_bit1: %0d cycles with level/strobe activity, want 0", bad);
        end
        checks++;
        if (level_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL bounce_bit0_hold: level[0]=%b, want 1", level_out[0]);
        end
    endtask

    task automatic test_repeat();
        int found = 0;
        int cnt = 0;
        int first = 0;
        int exp_cnt;
        int exp_first;
        raw_in = 4'h0;
        for (int c = 0; c < 20; c++) step();
        checks++;
        if (level_out !== 4'h0) begin
            errors++;
            $display("FAIL repeat_clear: level=%h, want 0", level_out);
        end
        raw_in = 4'h1;
        for (int c = 0; c < 20 && found == 0; c++) begin
            step();
            if (rise_pulse[0] === 1'b1) found = 1;
        end
        checks++;
        if (found != 1) begin
            errors++;
            $display("FAIL repeat_qualify: no rise within 20 cycles, want one");
        end
        for (int o = 1; o <= 41; o++) begin
            step();
            if (rise_pulse[0] === 1'b1) begin
                cnt++;
                if (first == 0) first = o;
            end
        end
`ifdef SWDB_REPEAT_EN
        exp_cnt   = 5;
        exp_first = 8;
`else
        exp_cnt   = 0;
        exp_first = 0;
`endif
        checks++;
        if (cnt != exp_cnt || first != exp_first) begin
            errors++;
            $display("FAIL repeat_pulses: count=%0d first=%0d, want count=%0d first=%0d",
                     cnt, first, exp_cnt, exp_first);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int early = 0;
        raw_in = 4'h0;
        for (int c = 0; c < 20; c++) step();
        raw_in = 4'h1;
        for (int c = 0; c < 6; c++) step();
        checks++;
        if (level_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pre: level[0]=%b, want 0", level_out[0]);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({level_out, rise_pulse, fall_pulse, any_change} !== 13'b0) begin
            errors++;
            $display("FAIL midreset_clear: got %b, want all 0",
                     {level_out, rise_pulse, fall_pulse, any_change});
        end
        rst = 1'b0;
        while (n < 20 && level_out[0] !== 1'b1) begin
            step();
            n++;
            if (level_out[0] !== 1'b1 && rise_pulse !== 4'h0) early++;
        end
        checks++;
        if (n != 12 || early != 0) begin
            errors++;
            $display("FAIL midreset_requalify: %0d cycles (%0d early strobes), want 12/0", n, early);
        end
        checks++;
        if (rise_pulse !== 4'h1) begin
            errors++;
            $display("FAIL midreset_rise: rise=%b, want 0001", rise_pulse);
        end
    endtask

    initial begin
        test_reset();
        test_pair_fall_low();
        test_simultaneous_fall();
        test_rise();
        test_bounce();
        test_repeat();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
